// File: rtl/calculadora_sequenciador.sv
// Accumulator controller around the combinational calculadora datapath.
// Takes commands over valid/ready, runs each for one cycle against the accumulator, returns flagged results.
module calculadora_sequenciador #(
    parameter int unsigned CONT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_codigo,
    input  logic [7:0]        cmd_operando,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_valor,
    output logic              res_vai_um,
    output logic              res_erro,
    output logic [7:0]        acumulador,
    output logic [CONT_W-1:0] contador,
    output logic [7:0]        calc_a,
    output logic [7:0]        calc_b,
    output logic [2:0]        calc_codigo,
    input  logic [7:0]        calc_saida
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned COD_W  = 3;

    localparam logic [COD_W-1:0] COD_ZERA   = 3'b000;
    localparam logic [COD_W-1:0] COD_MOSTRA = 3'b001;
    localparam logic [COD_W-1:0] COD_CARREGA = 3'b010;
    localparam logic [COD_W-1:0] COD_SOMA   = 3'b011;
    localparam logic [COD_W-1:0] COD_SUBTRAI = 3'b100;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EXECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [COD_W-1:0]    codigo_q, codigo_d;
    logic [DATA_W-1:0]   operando_q, operando_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CONT_W-1:0]   contador_q, contador_d;
    logic [DATA_W-1:0]   res_valor_q, res_valor_d;
    logic                res_vai_um_q, res_vai_um_d;
    logic                res_erro_q, res_erro_d;
    logic [DATA_W:0]     soma_c;
    logic                codigo_valido_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q     <= OCIOSO;
            codigo_q     <= COD_MOSTRA;
            operando_q   <= '0;
            acc_q        <= '0;
            contador_q   <= '0;
            res_valor_q  <= '0;
            res_vai_um_q <= 1'b0;
            res_erro_q   <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            codigo_q     <= codigo_d;
            operando_q   <= operando_d;
            acc_q        <= acc_d;
            contador_q   <= contador_d;
            res_valor_q  <= res_valor_d;
            res_vai_um_q <= res_vai_um_d;
            res_erro_q   <= res_erro_d;
        end
    end

    assign codigo_valido_c = (codigo_q <= COD_SUBTRAI);
    assign soma_c          = {1'b0, acc_q} + {1'b0, operando_q};

    // Next-state and result computation
    always_comb begin
        estado_d     = estado_q;
        codigo_d     = codigo_q;
        operando_d   = operando_q;
        acc_d        = acc_q;
        contador_d   = contador_q;
        res_valor_d  = res_valor_q;
        res_vai_um_d = res_vai_um_q;
        res_erro_d   = res_erro_q;

        unique case (estado_q)
            OCIOSO: begin
                if (cmd_valid) begin
                    codigo_d   = cmd_codigo;
                    operando_d = cmd_operando;
                    estado_d   = EXECUTA;
                end
            end
            EXECUTA: begin
                res_valor_d  = acc_q;
                res_erro_d   = !codigo_valido_c;
                res_vai_um_d = 1'b0;
                if (codigo_q == COD_ZERA || codigo_q == COD_CARREGA ||
                    codigo_q == COD_SOMA || codigo_q == COD_SUBTRAI) begin
                    acc_d       = calc_saida;
                    res_valor_d = calc_saida;
                end
                if (codigo_q == COD_SOMA) begin
                    res_vai_um_d = soma_c[DATA_W];
                end else if (codigo_q == COD_SUBTRAI) begin
                    res_vai_um_d = (acc_q < operando_q);
                end
                contador_d = contador_q + CONT_W'(1);
                estado_d   = RESPONDE;
            end
            RESPONDE: begin
                if (res_ready) begin
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    // Outputs come from registers or a pure state decode
    assign cmd_ready   = (estado_q == OCIOSO);
    assign res_valid   = (estado_q == RESPONDE);
    assign res_valor   = res_valor_q;
    assign res_vai_um  = res_vai_um_q;
    assign res_erro    = res_erro_q;
    assign acumulador  = acc_q;
    assign contador    = contador_q;
    assign calc_a      = acc_q;
    assign calc_b      = (estado_q == EXECUTA) ? operando_q : '0;
    assign calc_codigo = (estado_q == EXECUTA && codigo_valido_c) ? codigo_q : COD_MOSTRA;

endmodule

// File: tb/tb_calculadora_sequenciador.sv
// Randomized and directed bench for calculadora_sequenciador against an arithmetic reference model.
module tb_calculadora_sequenciador;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [2:0] cmd_codigo;
    logic [7:0] cmd_operando;
    logic       res_ready;

    logic       cmd_ready, res_valid, res_vai_um, res_erro;
    logic [7:0] res_valor, acumulador, calc_a, calc_b, calc_saida;
    logic [7:0] contador;
    logic [2:0] calc_codigo;

    logic       cmd_ready2, res_valid2, res_vai_um2, res_erro2;
    logic [7:0] res_valor2, acumulador2, calc_a2, calc_b2, calc_saida2;
    logic [1:0] contador2;
    logic [2:0] calc_codigo2;

    int vectors = 0;
    int miscompares = 0;

    int         m_acc;
    int         m_cnt;
    logic [7:0] m_valor;
    logic       m_vai;
    logic       m_erro;

    always #5 clk = ~clk;

    calculadora_sequenciador #(.CONT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_codigo(cmd_codigo), .cmd_operando(cmd_operando),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_valor(res_valor), .res_vai_um(res_vai_um), .res_erro(res_erro),
        .acumulador(acumulador), .contador(contador),
        .calc_a(calc_a), .calc_b(calc_b), .calc_codigo(calc_codigo),
        .calc_saida(calc_saida)
    );

    calculadora_sequenciador #(.CONT_W(2)) dut_w2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_codigo(cmd_codigo), .cmd_operando(cmd_operando),
        .res_valid(res_valid2), .res_ready(res_ready),
        .res_valor(res_valor2), .res_vai_um(res_vai_um2), .res_erro(res_erro2),
        .acumulador(acumulador2), .contador(contador2),
        .calc_a(calc_a2), .calc_b(calc_b2), .calc_codigo(calc_codigo2),
        .calc_saida(calc_saida2)
    );

    // Stand-in for the combinational calculadora datapath
    function automatic logic [7:0] calculadora(input logic [7:0] a, input logic [7:0] b,
                                               input logic [2:0] cod);
        case (cod)
            3'd0:    return 8'h00;
            3'd1:    return a;
            3'd2:    return b;
            3'd3:    return a + b;
            3'd4:    return a - b;
            default: return 8'hEE;
        endcase
    endfunction

    always_comb calc_saida  = calculadora(calc_a, calc_b, calc_codigo);
    always_comb calc_saida2 = calculadora(calc_a2, calc_b2, calc_codigo2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_apply(input logic [2:0] cod, input logic [7:0] b);
        int sum;
        m_vai  = 1'b0;
        m_erro = 1'b0;
        case (cod)
            3'd0: m_acc = 0;
            3'd1: ;
            3'd2: m_acc = b;
            3'd3: begin
                sum   = m_acc + int'(b);
                m_vai = (sum > 255);
                m_acc = sum % 256;
            end
            3'd4: begin
                m_vai = (m_acc < int'(b));
                m_acc = (m_acc - int'(b) + 256) % 256;
            end
            default: m_erro = 1'b1;
        endcase
        m_valor = 8'(m_acc);
        m_cnt   = m_cnt + 1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_calc_codigo"}, 32'(calc_codigo), 32'd1);
        check({tag, "_calc_b"}, 32'(calc_b), 32'd0);
        check({tag, "_acc"}, 32'(acumulador), 32'(m_acc));
        check({tag, "_cnt"}, 32'(contador), 32'(m_cnt % 256));
        check({tag, "_acc2"}, 32'(acumulador2), 32'(m_acc));
        check({tag, "_cnt2"}, 32'(contador2), 32'(m_cnt % 4));
        check({tag, "_valor"}, 32'(res_valor), 32'(m_valor));
        check({tag, "_vai"}, 32'(res_vai_um), 32'(m_vai));
        check({tag, "_erro"}, 32'(res_erro), 32'(m_erro));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        m_acc = 0; m_cnt = 0; m_valor = 8'h00; m_vai = 1'b0; m_erro = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check("reset_calc_a", 32'(calc_a), 32'd0);
    endtask

    // One full command: accept, execute, respond with optional back-pressure
    task automatic do_cmd(input logic [2:0] cod, input logic [7:0] b, input int hold, input bit bp);
        logic [7:0] acc_before;
        @(negedge clk);
        check("pre_cmd_ready", 32'(cmd_ready), 32'd1);
        acc_before = 8'(m_acc);
        cmd_valid = 1'b1; cmd_codigo = cod; cmd_operando = b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
        check("exec_res_valid", 32'(res_valid), 32'd0);
        check("exec_calc_a", 32'(calc_a), 32'(acc_before));
        check("exec_calc_b", 32'(calc_b), 32'(b));
        check("exec_calc_codigo", 32'(calc_codigo), (cod > 3'd4) ? 32'd1 : 32'(cod));
        if (bp) begin
            cmd_valid = 1'b1; cmd_codigo = 3'd2; cmd_operando = ~b;
        end
        model_apply(cod, b);
        @(negedge clk);
        check("res_valid", 32'(res_valid), 32'd1);
        check("res_valid2", 32'(res_valid2), 32'd1);
        check("res_cmd_ready", 32'(cmd_ready), 32'd0);
        check("res_valor", 32'(res_valor), 32'(m_valor));
        check("res_vai_um", 32'(res_vai_um), 32'(m_vai));
        check("res_erro", 32'(res_erro), 32'(m_erro));
        check("res_acc", 32'(acumulador), 32'(m_acc));
        check("res_cnt", 32'(contador), 32'(m_cnt % 256));
        check("res_cnt2", 32'(contador2), 32'(m_cnt % 4));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_res_valid", 32'(res_valid), 32'd1);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_res_valor", 32'(res_valor), 32'(m_valor));
            check("hold_res_vai_erro", {30'd0, res_vai_um, res_erro}, {30'd0, m_vai, m_erro});
            check("hold_acc", 32'(acumulador), 32'(m_acc));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check_idle("after");
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_codigo = 3'd0; cmd_operando = 8'h00; res_ready = 1'b0;
        do_reset();

        do_cmd(3'd2, 8'hC8, 0, 1'b0);
        check("load_c8", 32'(res_valor), 32'hC8);
        do_cmd(3'd3, 8'h64, 0, 1'b0);
        check("add_2c", {23'd0, res_vai_um, res_valor}, {23'd0, 1'b1, 8'h2C});
        check("cnt_two", 32'(contador), 32'd2);

        do_cmd(3'd2, 8'h05, 1, 1'b0);
        do_cmd(3'd4, 8'h07, 0, 1'b0);
        check("sub_fe", {23'd0, res_vai_um, res_valor}, {23'd0, 1'b1, 8'hFE});
        do_cmd(3'd1, 8'h5A, 0, 1'b0);
        check("show_fe", {24'd0, res_valor}, 32'hFE);
        do_cmd(3'd0, 8'h11, 0, 1'b0);
        check("zero", 32'(res_valor), 32'h00);

        do_cmd(3'd2, 8'h10, 0, 1'b0);
        do_cmd(3'd6, 8'h33, 0, 1'b0);
        check("err_flag", {23'd0, res_erro, res_valor}, {23'd0, 1'b1, 8'h10});

        do_cmd(3'd3, 8'hF5, 5, 1'b1);

        // Reset with a result pending must discard it
        @(negedge clk);
        cmd_valid = 1'b1; cmd_codigo = 3'd2; cmd_operando = 8'h77;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_res_valid", 32'(res_valid), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", {30'd0, res_valid, res_valid2}, 32'd0);
        end

        for (int n = 0; n < 300; n++) begin
            do_cmd(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
